// File: rtl/cpu_mem_responder.sv
// Word-addressed memory serving the CPU fetch and load/store buses with one-cycle
// registered reads, an optional post-reset zeroing pass and sticky error flags.
module cpu_mem_responder #(
    parameter int DEPTH          = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_addr,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] instr_out,
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        err_oob,
    output logic        err_misalign,
    input  logic        err_clr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [31:0]     instr_out_q, instr_out_d;
    logic [31:0]     data_out_q, data_out_d;
    logic            errOob_q, errOob_d;
    logic            errMis_q, errMis_d;

    logic [31:0]     mem [DEPTH];

    logic [AW-1:0]   instrIdx, dataIdx;
    logic            instrOob, dataOob;
    logic [31:0]     instrWord, dataWord;
    logic            running;
    logic            clearEn, fetchEn, loadEn, storeReq, storeEn;
    logic            newOob, newMis;

    assign instrIdx  = instr_addr[AW+1:2];
    assign dataIdx   = data_addr[AW+1:2];
    assign instrOob  = |instr_addr[31:AW+2];
    assign dataOob   = |data_addr[31:AW+2];
    assign instrWord = mem[instrIdx];
    assign dataWord  = mem[dataIdx];
    assign running   = (state_q == RUN);

    // Next-state, request qualification and output/flag updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        instr_out_d = instr_out_q;
        data_out_d  = data_out_q;
        clearEn     = 1'b0;
        fetchEn     = 1'b0;
        loadEn      = 1'b0;
        storeReq    = 1'b0;
        storeEn     = 1'b0;
        newOob      = 1'b0;
        newMis      = 1'b0;

        unique case (state_q)
            INIT: begin
                clearEn = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                fetchEn  = instr_read;
                loadEn   = data_read;
                storeReq = |data_write;
                storeEn  = storeReq && !dataOob;
            end
            default: state_d = state_q;
        endcase

        if (fetchEn) begin
            instr_out_d = instrOob ? 32'h0 : instrWord;
        end
        if (loadEn) begin
            data_out_d = dataOob ? 32'h0 : (dataWord >> {data_addr[1:0], 3'b000});
        end

        newOob = (fetchEn && instrOob) || ((loadEn || storeReq) && dataOob);
        newMis = (fetchEn && (instr_addr[1:0] != 2'b00)) ||
                 (storeReq && (data_write == 4'b1111) && (data_addr[1:0] != 2'b00));

        errOob_d = (errOob_q && !err_clr) || newOob;
        errMis_d = (errMis_q && !err_clr) || newMis;
    end

    // State and output registers; the array itself is deliberately left out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR_ON_RESET ? INIT : RUN;
            cnt_q       <= '0;
            instr_out_q <= '0;
            data_out_q  <= '0;
            errOob_q    <= 1'b0;
            errMis_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            instr_out_q <= instr_out_d;
            data_out_q  <= data_out_d;
            errOob_q    <= errOob_d;
            errMis_q    <= errMis_d;
        end
    end

    // Reads above see the pre-edge contents, giving read-before-write on collisions
    always_ff @(posedge clk) begin
        if (clearEn) begin
            mem[cnt_q] <= '0;
        end else if (storeEn) begin
            for (int i = 0; i < 4; i++) begin
                if (data_write[i]) begin
                    mem[dataIdx][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    assign instr_out    = instr_out_q;
    assign data_out     = data_out_q;
    assign mem_ready    = running;
    assign err_oob      = errOob_q;
    assign err_misalign = errMis_q;

endmodule
